parking_occupancy_ctrl: RTL and testbench
=========================================

PARKING_OCCUPANCY_CTRL -- requirements
Module: parking_occupancy_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Parameter CAPACITY, default 9, number of slots; legal range 1..15.
REQ-003 Parameter DEB_CYCLES, default 4, debounce stability length in cycles; legal range 1..255.
REQ-004 Parameter HOLD_MAX, default 1000, gate-open timeout in cycles; legal range 1..65535.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 entry_sensor  input  1  raw car-present sensor at the entry lane; asynchronous to clk.
REQ-008 exit_sensor  input  1  raw car-present sensor at the exit lane; asynchronous to clk.
REQ-009 free_slots  output  4  registered count of free slots; drives the seven-segment decoder digit input.
REQ-010 full  output  1  registered; high when free_slots is 0.
REQ-011 gate_in_open  output  1  registered entry barrier command.
REQ-012 gate_out_open  output  1  registered exit barrier command.
REQ-013 reject  output  1  one-cycle pulse on an entry refused (lot full) or an exit refused (lot empty).
REQ-014 timeout  output  1  one-cycle pulse when a gate closes after HOLD_MAX cycles without the car passing.

Function
REQ-015 Each sensor SHALL pass through a 2-flop synchronizer and then a debouncer; the debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles.
REQ-016 Raw level stable from edge E SHALL yield the corresponding FSM/output change at edge E+DEB_CYCLES+3: 2 edges for synchronization, DEB_CYCLES for debounce, 1 for the FSM register.
REQ-017 A debounced rising edge is an "arrive" event; a debounced falling edge is a "leave" event; each is a single-cycle internal strobe.
REQ-018 FSM states SHALL be IDLE, IN_OPEN and OUT_OPEN.
REQ-019 IDLE with entry-arrive and free_slots>0: go to IN_OPEN and assert gate_in_open.
REQ-020 IDLE with entry-arrive and free_slots==0: remain in IDLE and pulse reject.
REQ-021 IDLE with exit-arrive and free_slots<CAPACITY: go to OUT_OPEN and assert gate_out_open.
REQ-022 IDLE with exit-arrive and free_slots==CAPACITY: remain in IDLE and pulse reject.
REQ-023 Simultaneous entry-arrive and exit-arrive in IDLE: exit wins; the entry event is discarded, with no reject pulse.
REQ-024 IN_OPEN on entry-leave: decrement free_slots, deassert gate_in_open and return to IDLE, all at the same edge.
REQ-025 OUT_OPEN on exit-leave: increment free_slots, deassert gate_out_open and return to IDLE, all at the same edge.
REQ-026 In IN_OPEN and OUT_OPEN, all events on the other sensor SHALL be ignored and are not queued.
REQ-027 A hold counter SHALL clear on entry to IN_OPEN/OUT_OPEN; if it reaches HOLD_MAX without the leave event, the FSM returns to IDLE, closes the gate, pulses timeout and leaves free_slots unchanged.
REQ-028 free_slots SHALL never go below 0 or above CAPACITY; no wrap-around.
REQ-029 full SHALL be registered and consistent with free_slots in the same cycle.
REQ-030 At most one gate output SHALL be high in any cycle.

Reset
REQ-031 On rst high at a clock edge: state=IDLE, free_slots=CAPACITY, full=0, gate_in_open=0, gate_out_open=0, reject=0, timeout=0.
REQ-032 On rst: synchronizers and debounced levels cleared to 0, and debounce and hold counters cleared to 0.
REQ-033 Reset mid-operation (gate open) SHALL close the gate at that edge and discard the pending count change.
REQ-034 A sensor held high through reset release SHALL produce an arrive event after the normal REQ-016 latency.

Structure
REQ-035 A shared package parking_pkg SHALL hold the FSM state enum and the default CAPACITY, DEB_CYCLES and HOLD_MAX constants.
REQ-036 Synchronizer plus debouncer SHALL be one sub-module, sensor_debounce, instantiated twice.
REQ-037 The FSM, occupancy counter and hold counter SHALL reside in parking_occupancy_ctrl.

Verification
REQ-038 Reset, then entry pulse held 10 cycles with DEB_CYCLES=4: gate_in_open rises at edge E+7; at release plus 7 edges, free_slots goes 9->8 and the gate closes.
REQ-039 Fill the lot with 9 entries, then a 10th entry: full=1, free_slots=0, one reject pulse, gate_in_open stays 0.
REQ-040 Exit with free_slots=9: reject pulses once, gate_out_open stays 0, free_slots stays 9.
REQ-041 Entry and exit raw rising on the same edge with free_slots=5: gate_out_open opens, gate_in_open stays 0; after exit-leave, free_slots=6.
REQ-042 With HOLD_MAX=20, entry held high for 100 cycles: timeout pulses once, 20 cycles after the gate opened, the gate closes and free_slots is unchanged.
REQ-043 3-cycle glitches on entry_sensor with DEB_CYCLES=4: no gate activity; then rst asserted while gate_out_open=1: gate closes and free_slots returns to CAPACITY.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types and default parameters for the parking occupancy controller.
// The state enum is used by the FSM; the defaults seed the top-level parameters.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_OPEN  = 2'd1,
      OUT_OPEN = 2'd2
   } park_state_t;

   localparam int DEF_CAPACITY   = 9;
   localparam int DEF_DEB_CYCLES = 4;
   localparam int DEF_HOLD_MAX   = 1000;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus debouncer for one raw car-present sensor.
// Emits one-cycle arrive/leave strobes on debounced rising/falling edges.
module sensor_debounce
   import parking_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic arrive,
   output logic leave
);

   localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

   logic       sync_p0;
   logic       sync_p1;
   logic       level_q;
   logic       level_d;
   logic [7:0] deb_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level_q <= 1'b0;
         level_d <= 1'b0;
         deb_cnt <= 8'd0;
         arrive  <= 1'b0;
         leave   <= 1'b0;
      end else begin
         // synchronizer stage boundary
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         // level changes only after DEB_CYCLES consecutive disagreeing samples
         if (sync_p1 != level_q) begin
            if (deb_cnt == DEB_LAST) begin
               level_q <= sync_p1;
               deb_cnt <= 8'd0;
            end else begin
               deb_cnt <= deb_cnt + 8'd1;
            end
         end else begin
            deb_cnt <= 8'd0;
         end
         // edge-strobe stage boundary
         level_d <= level_q;
         arrive  <= level_q & ~level_d;
         leave   <= ~level_q & level_d;
      end
   end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Parking lot gate controller: debounced entry/exit sensors drive a three-state
// FSM that opens one barrier at a time and tracks the number of free slots.
module parking_occupancy_ctrl
   import parking_pkg::*;
#(
   parameter int CAPACITY   = DEF_CAPACITY,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int HOLD_MAX   = DEF_HOLD_MAX
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   output logic [3:0] free_slots,
   output logic       full,
   output logic       gate_in_open,
   output logic       gate_out_open,
   output logic       reject,
   output logic       timeout
);

   localparam logic [3:0]  CAP4      = 4'(CAPACITY);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

   logic entry_arrive;
   logic entry_leave;
   logic exit_arrive;
   logic exit_leave;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_entry_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (entry_sensor),
      .arrive (entry_arrive),
      .leave  (entry_leave)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (exit_sensor),
      .arrive (exit_arrive),
      .leave  (exit_leave)
   );

   park_state_t state;
   park_state_t state_nxt;
   logic [15:0] hold_cnt;
   logic        hold_done;
   logic [3:0]  free_nxt;
   logic        reject_nxt;
   logic        timeout_nxt;

   assign hold_done = (hold_cnt == HOLD_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         free_slots    <= CAP4;
         full          <= 1'b0;
         gate_in_open  <= 1'b0;
         gate_out_open <= 1'b0;
         reject        <= 1'b0;
         timeout       <= 1'b0;
         hold_cnt      <= 16'd0;
      end else begin
         state         <= state_nxt;
         free_slots    <= free_nxt;
         full          <= (free_nxt == 4'd0);
         gate_in_open  <= (state_nxt == IN_OPEN);
         gate_out_open <= (state_nxt == OUT_OPEN);
         reject        <= reject_nxt;
         timeout       <= timeout_nxt;
         // restarts on every state change, so it is zero on gate opening
         if (state_nxt != state || state == IDLE) begin
            hold_cnt <= 16'd0;
         end else begin
            hold_cnt <= hold_cnt + 16'd1;
         end
      end
   end

   // exit requests take priority over a simultaneous entry request
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (exit_arrive) begin
               if (free_slots != CAP4) state_nxt = OUT_OPEN;
            end else if (entry_arrive) begin
               if (free_slots != 4'd0) state_nxt = IN_OPEN;
            end
         end
         IN_OPEN: begin
            if (entry_leave || hold_done) state_nxt = IDLE;
         end
         OUT_OPEN: begin
            if (exit_leave || hold_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      free_nxt    = free_slots;
      reject_nxt  = 1'b0;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (exit_arrive) begin
               reject_nxt = (free_slots == CAP4);
            end else if (entry_arrive) begin
               reject_nxt = (free_slots == 4'd0);
            end
         end
         IN_OPEN: begin
            if (entry_leave) begin
               if (free_slots != 4'd0) free_nxt = free_slots - 4'd1;
            end else if (hold_done) begin
               timeout_nxt = 1'b1;
            end
         end
         OUT_OPEN: begin
            if (exit_leave) begin
               if (free_slots != CAP4) free_nxt = free_slots + 4'd1;
            end else if (hold_done) begin
               timeout_nxt = 1'b1;
            end
         end
         default: begin
            free_nxt = free_slots;
         end
      endcase
   end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Scoreboard bench for parking_occupancy_ctrl: a sample-history reference model
// predicts every cycle's outputs, a negedge monitor compares them.
module tb_parking_occupancy_ctrl;

   localparam int CAP  = 9;
   localparam int DEB  = 4;
   localparam int HOLD = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       entry_sensor;
   logic       exit_sensor;
   logic [3:0] free_slots;
   logic       full;
   logic       gate_in_open;
   logic       gate_out_open;
   logic       reject;
   logic       timeout;

   always #5 clk = ~clk;

   parking_occupancy_ctrl #(
      .CAPACITY   (CAP),
      .DEB_CYCLES (DEB),
      .HOLD_MAX   (HOLD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .entry_sensor  (entry_sensor),
      .exit_sensor   (exit_sensor),
      .free_slots    (free_slots),
      .full          (full),
      .gate_in_open  (gate_in_open),
      .gate_out_open (gate_out_open),
      .reject        (reject),
      .timeout       (timeout)
   );

   typedef struct packed {
      logic [3:0] free;
      logic       full;
      logic       gin;
      logic       gout;
      logic       rej;
      logic       tmo;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   mon_cycle = 0;

   // reference model: raw sample history per sensor, events delayed to the FSM
   bit hist [2][$];
   bit lvl [2];
   int d1 [2];
   int d2 [2];
   int m_mode;   // 0 = both gates closed, 1 = entry gate open, 2 = exit gate open
   int m_free;
   int m_edge;
   int m_opened;

   function automatic void clear_pipe();
      for (int s = 0; s < 2; s++) begin
         hist[s].delete();
         for (int k = 0; k < DEB + 2; k++) hist[s].push_back(1'b0);
         lvl[s] = 1'b0;
         d1[s]  = 0;
         d2[s]  = 0;
      end
   endfunction

   // returns 1 on a debounced rise, 2 on a fall, 0 otherwise
   function automatic int deb_step(int s, bit sample);
      int ev;
      bit all_diff;
      ev = 0;
      all_diff = 1'b1;
      for (int k = 1; k <= DEB; k++)
         if (hist[s][hist[s].size() - 1 - k] == lvl[s]) all_diff = 1'b0;
      if (all_diff) begin
         lvl[s] = ~lvl[s];
         ev = lvl[s] ? 1 : 2;
      end
      hist[s].push_back(sample);
      if (hist[s].size() > DEB + 2) void'(hist[s].pop_front());
      return ev;
   endfunction

   function automatic exp_t model_step(bit e, bit xs, bit r);
      exp_t o;
      int ev_en;
      int ev_ex;
      bit rej;
      bit tmo;
      rej = 1'b0;
      tmo = 1'b0;
      m_edge++;
      if (r) begin
         clear_pipe();
         m_mode = 0;
         m_free = CAP;
      end else begin
         ev_en = d2[0];
         ev_ex = d2[1];
         case (m_mode)
            0: begin
               if (ev_ex == 1) begin
                  if (m_free < CAP) begin m_mode = 2; m_opened = m_edge; end
                  else rej = 1'b1;
               end else if (ev_en == 1) begin
                  if (m_free > 0) begin m_mode = 1; m_opened = m_edge; end
                  else rej = 1'b1;
               end
            end
            1: begin
               if (ev_en == 2) begin m_free = m_free - 1; m_mode = 0; end
               else if (m_edge - m_opened == HOLD) begin m_mode = 0; tmo = 1'b1; end
            end
            default: begin
               if (ev_ex == 2) begin m_free = m_free + 1; m_mode = 0; end
               else if (m_edge - m_opened == HOLD) begin m_mode = 0; tmo = 1'b1; end
            end
         endcase
         d2[0] = d1[0];
         d2[1] = d1[1];
         d1[0] = deb_step(0, e);
         d1[1] = deb_step(1, xs);
      end
      o.free = 4'(m_free);
      o.full = (m_free == 0);
      o.gin  = (m_mode == 1);
      o.gout = (m_mode == 2);
      o.rej  = rej;
      o.tmo  = tmo;
      return o;
   endfunction

   task automatic cyc(input bit e, input bit xs, input bit r);
      entry_sensor = e;
      exit_sensor  = xs;
      rst          = r;
      sbq.push_back(model_step(e, xs, r));
      @(posedge clk);
      #1;
   endtask

   task automatic hold_in(input bit e, input bit xs, input int n);
      for (int i = 0; i < n; i++) cyc(e, xs, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t ex;
      exp_t ac;
      if (sbq.size() > 0) begin
         ex = sbq.pop_front();
         ac = '{free: free_slots, full: full, gin: gate_in_open,
                gout: gate_out_open, rej: reject, tmo: timeout};
         checks++;
         if (ac !== ex) begin
            errors++;
            $display("FAIL outputs cycle %0d: got free=%0d full=%0b gin=%0b gout=%0b rej=%0b tmo=%0b, required free=%0d full=%0b gin=%0b gout=%0b rej=%0b tmo=%0b",
                     mon_cycle, ac.free, ac.full, ac.gin, ac.gout, ac.rej, ac.tmo,
                     ex.free, ex.full, ex.gin, ex.gout, ex.rej, ex.tmo);
         end
         mon_cycle++;
      end
   end

   initial begin
      bit e;
      bit xs;
      int n;
      m_edge   = 0;
      m_opened = 0;
      m_mode   = 0;
      m_free   = CAP;
      clear_pipe();

      repeat (3) cyc(1'b0, 1'b0, 1'b1);
      hold_in(0, 0, 5);
      // exit request with the lot empty
      hold_in(0, 1, 8);  hold_in(0, 0, 12);
      // single entry
      hold_in(1, 0, 10); hold_in(0, 0, 12);
      // fill the lot, the last entry is refused
      repeat (9) begin hold_in(1, 0, 10); hold_in(0, 0, 12); end
      // drain to five free slots
      repeat (5) begin hold_in(0, 1, 10); hold_in(0, 0, 12); end
      // simultaneous arrival on both lanes
      hold_in(1, 1, 10); hold_in(0, 0, 12);
      // car parked in the entry lane
      hold_in(1, 0, 100); hold_in(0, 0, 12);
      // short glitches
      repeat (4) begin hold_in(1, 0, 3); hold_in(0, 0, 5); end
      // reset with the exit gate open
      hold_in(0, 1, 10); cyc(0, 1, 1); hold_in(0, 0, 12);
      // sensor held high through reset release
      hold_in(1, 0, 5); cyc(1, 0, 1); hold_in(1, 0, 12); hold_in(0, 0, 12);

      for (int seg = 0; seg < 250; seg++) begin
         e  = 1'($urandom_range(0, 1));
         xs = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 25);
         if ($urandom_range(0, 59) == 0) cyc(e, xs, 1'b1);
         hold_in(e, xs, n);
      end
      hold_in(0, 0, 30);

      @(negedge clk);
      #1;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
